// File: rtl/wire_cmd_sequencer_if.sv
// WireIn/WireOut bundle between the FrontPanel endpoints and wire_cmd_sequencer.
// master = host/endpoint side, slave = sequencer side.
interface wire_cmd_sequencer_if #(
   parameter int WIDTH = 32
);
   logic [31:0]      cmd_wire;
   logic [WIDTH-1:0] opa_wire;
   logic [WIDTH-1:0] opb_wire;
   logic [WIDTH-1:0] result;
   logic [31:0]      status;
   logic             busy;

   modport master (
      output cmd_wire, opa_wire, opb_wire,
      input  result, status, busy
   );

   modport slave (
      input  cmd_wire, opa_wire, opb_wire,
      output result, status, busy
   );
endinterface

// File: rtl/wire_cmd_sequencer.sv
// Host-driven command sequencer: a rising go bit latches opcode/operands, runs the op
// and posts registered result/status. Define SEQ_MUL_EN to build the shift-add MUL.
module wire_cmd_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic                okClk,
   input  logic                rst_n,
   wire_cmd_sequencer_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [3:0] OP_NOP = 4'd0;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [3:0] OP_SUB = 4'd2;
   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_ACC = 4'd4;
   localparam logic [3:0] OP_CLR = 4'd5;

   logic [1:0]       state_q, state_d;
   logic             go_q;
   logic             start_s;
   logic             complete_s;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             overrun_q, overrun_d;
   logic             busy_q, busy_d;
   logic [7:0]       seq_q, seq_d;
   logic             unused_cmd_s;
`ifdef SEQ_MUL_EN
   localparam logic [5:0] MUL_LAST = 6'(WIDTH - 1);
   logic [WIDTH-1:0] prod_q, prod_d;
   logic [5:0]       cnt_q, cnt_d;
`endif

   assign start_s      = bus.cmd_wire[31] & ~go_q;
   assign unused_cmd_s = ^bus.cmd_wire[30:4];

   // Next-state decode: start acceptance, per-opcode execution and completion.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      result_d   = result_q;
      done_d     = done_q;
      error_d    = error_q;
      overrun_d  = overrun_q;
      seq_d      = seq_q;
      complete_s = 1'b0;
`ifdef SEQ_MUL_EN
      prod_d     = prod_q;
      cnt_d      = cnt_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_s) begin
               op_d      = bus.cmd_wire[3:0];
               a_d       = bus.opa_wire;
               b_d       = bus.opb_wire;
               done_d    = 1'b0;
               error_d   = 1'b0;
               overrun_d = 1'b0;
               state_d   = ST_EXEC;
`ifdef SEQ_MUL_EN
               prod_d    = {WIDTH{1'b0}};
               cnt_d     = 6'd0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_EXEC: begin
            // Any start here is dropped, including one landing on the completion edge.
            if (start_s) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            complete_s = 1'b1;
            case (op_q)
               OP_NOP: result_d = result_q;
               OP_ADD: result_d = a_q + b_q;
               OP_SUB: result_d = a_q - b_q;
`ifdef SEQ_MUL_EN
               OP_MUL: begin
                  prod_d = prod_q + (b_q[0] ? a_q : {WIDTH{1'b0}});
                  a_d    = a_q << 1;
                  b_d    = b_q >> 1;
                  cnt_d  = cnt_q + 6'd1;
                  if (cnt_q == MUL_LAST) begin
                     result_d = prod_d;
                  end else begin
                     complete_s = 1'b0;
                  end
               end
`endif
               OP_ACC: begin
                  acc_d    = acc_q + a_q;
                  result_d = acc_d;
               end
               OP_CLR: begin
                  acc_d    = {WIDTH{1'b0}};
                  result_d = {WIDTH{1'b0}};
               end
               default: error_d = 1'b1;
            endcase
            if (complete_s) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               seq_d   = seq_q + 8'd1;
            end else begin
               state_d = ST_EXEC;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_EXEC);
   end

   // Control and datapath registers; reset aborts any operation and clears acc.
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         go_q      <= 1'b0;
         op_q      <= 4'd0;
         a_q       <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         acc_q     <= {WIDTH{1'b0}};
         result_q  <= {WIDTH{1'b0}};
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
         seq_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         go_q      <= bus.cmd_wire[31];
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
         done_q    <= done_d;
         error_q   <= error_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
         seq_q     <= seq_d;
      end
   end

`ifdef SEQ_MUL_EN
   // Shift-add multiplier partial product and bit counter.
   always_ff @(posedge okClk or negedge rst_n) begin
      if (!rst_n) begin
         prod_q <= {WIDTH{1'b0}};
         cnt_q  <= 6'd0;
      end else begin
         prod_q <= prod_d;
         cnt_q  <= cnt_d;
      end
   end
`endif

   assign bus.result = result_q;
   assign bus.busy   = busy_q;
   assign bus.status = {16'h0000, seq_q, op_q, overrun_q, error_q, done_q, busy_q};

endmodule

// File: tb/tb_wire_cmd_sequencer.sv
// Directed bench for wire_cmd_sequencer; expectations follow SEQ_MUL_EN when defined.
module tb_wire_cmd_sequencer;
   localparam int WIDTH = 32;

   logic okClk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;
   int   seq_e = 0;
   int   cyc;
   int   max_cyc;
   logic [31:0] seq0;

   wire_cmd_sequencer_if #(.WIDTH(WIDTH)) bus ();

   wire_cmd_sequencer #(.WIDTH(WIDTH)) dut (
      .okClk (okClk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 okClk = ~okClk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] st(input int seq, input logic [3:0] op,
                                      input logic ovr, input logic err, input logic done);
      return {16'h0000, 8'(seq), op, ovr, err, done, 1'b0};
   endfunction

   // Raise go with the given op, then count busy cycles while scrambling the WireIns.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input int pulse_at, output int n);
      @(negedge okClk);
      bus.cmd_wire = {1'b1, 27'd0, op};
      bus.opa_wire = a;
      bus.opb_wire = b;
      n = 0;
      @(negedge okClk);
      while (bus.busy === 1'b1 && n < 200) begin
         n++;
         bus.cmd_wire[31]  = hold || (n == pulse_at);
         bus.cmd_wire[3:0] = ~op;
         bus.opa_wire      = ~a;
         bus.opb_wire      = ~b;
         @(negedge okClk);
      end
      bus.cmd_wire[31] = hold;
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.cmd_wire = 32'd0;
      bus.opa_wire = 32'd0;
      bus.opb_wire = 32'd0;
      repeat (3) @(negedge okClk);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_status", bus.status, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;

      // ADD wraps modulo 2^32
      run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 0, cyc); seq_e++;
      chk("add_cycles", 32'(cyc), 32'd1);
      chk("add_result", bus.result, 32'h0000_0001);
      chk("add_status", bus.status, st(seq_e, 4'd1, 1'b0, 1'b0, 1'b1));

      // (2^16+3)*(2^17+5) mod 2^32 = 0x000B000F
      run_op(4'd3, 32'h0001_0003, 32'h0002_0005, 1'b0, 0, cyc); seq_e++;
`ifdef SEQ_MUL_EN
      chk("mul_cycles", 32'(cyc), 32'd32);
      chk("mul_result", bus.result, 32'h000B_000F);
      chk("mul_status", bus.status, st(seq_e, 4'd3, 1'b0, 1'b0, 1'b1));
`else
      chk("mul_cycles", 32'(cyc), 32'd1);
      chk("mul_result", bus.result, 32'h0000_0001);
      chk("mul_status", bus.status, st(seq_e, 4'd3, 1'b0, 1'b1, 1'b1));
`endif

      // go held high through and past completion must not retrigger
      run_op(4'd1, 32'd3, 32'd4, 1'b1, 0, cyc); seq_e++;
      repeat (4) @(negedge okClk);
      chk("hold_cycles", 32'(cyc), 32'd1);
      chk("hold_busy", 32'(bus.busy), 32'd0);
      chk("hold_result", bus.result, 32'd7);
      chk("hold_status", bus.status, st(seq_e, 4'd1, 1'b0, 1'b0, 1'b1));
      bus.cmd_wire[31] = 1'b0;
      @(negedge okClk);

`ifdef SEQ_MUL_EN
      run_op(4'd3, 32'd6, 32'd7, 1'b0, 5, cyc); seq_e++;
      chk("ovr_mid_cycles", 32'(cyc), 32'd32);
      chk("ovr_mid_result", bus.result, 32'd42);
      chk("ovr_mid_status", bus.status, st(seq_e, 4'd3, 1'b1, 1'b0, 1'b1));
      run_op(4'd3, 32'd9, 32'd9, 1'b0, WIDTH, cyc); seq_e++;
      chk("ovr_end_cycles", 32'(cyc), 32'd32);
      chk("ovr_end_result", bus.result, 32'd81);
      chk("ovr_end_status", bus.status, st(seq_e, 4'd3, 1'b1, 1'b0, 1'b1));
`endif

      // clean start clears overrun; SUB wraps below zero
      run_op(4'd2, 32'd3, 32'd10, 1'b0, 0, cyc); seq_e++;
      chk("sub_result", bus.result, 32'hFFFF_FFF9);
      chk("sub_status", bus.status, st(seq_e, 4'd2, 1'b0, 1'b0, 1'b1));

      run_op(4'd5, 32'h1234, 32'h5678, 1'b0, 0, cyc); seq_e++;
      chk("clr_result", bus.result, 32'd0);
      chk("clr_status", bus.status, st(seq_e, 4'd5, 1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 3; i++) begin
         run_op(4'd4, 32'd5, 32'd99, 1'b0, 0, cyc); seq_e++;
      end
      chk("acc_result", bus.result, 32'd15);
      chk("acc_status", bus.status, st(seq_e, 4'd4, 1'b0, 1'b0, 1'b1));

      run_op(4'd9, 32'd1, 32'd1, 1'b0, 0, cyc); seq_e++;
      chk("ill_cycles", 32'(cyc), 32'd1);
      chk("ill_result", bus.result, 32'd15);
      chk("ill_status", bus.status, st(seq_e, 4'd9, 1'b0, 1'b1, 1'b1));

      // 256 completions bring seq_count back to where it started
      seq0    = 32'(bus.status[15:8]);
      max_cyc = 0;
      for (int i = 0; i < 256; i++) begin
         run_op(4'd0, 32'(i), 32'(i), 1'b0, 0, cyc);
         if (cyc > max_cyc) max_cyc = cyc;
      end
      seq_e += 256;
      chk("wrap_seq", 32'(bus.status[15:8]), seq0);
      chk("wrap_cycles", 32'(max_cyc), 32'd1);
      chk("wrap_result", bus.result, 32'd15);
      chk("wrap_status", bus.status, st(seq_e, 4'd0, 1'b0, 1'b0, 1'b1));

      // reset in the middle of an operation
      @(negedge okClk);
`ifdef SEQ_MUL_EN
      bus.cmd_wire = {1'b1, 27'd0, 4'd3};
      @(negedge okClk);
      bus.cmd_wire[31] = 1'b0;
      repeat (9) @(negedge okClk);
`else
      bus.cmd_wire = {1'b1, 27'd0, 4'd4};
      @(negedge okClk);
      bus.cmd_wire[31] = 1'b0;
`endif
      chk("midrst_pre_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_status", bus.status, 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      @(negedge okClk);
      rst_n = 1'b1;
      run_op(4'd4, 32'd5, 32'd0, 1'b0, 0, cyc);
      chk("postrst_acc", bus.result, 32'd5);
      chk("postrst_status", bus.status, st(1, 4'd4, 1'b0, 1'b0, 1'b1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
